// File: rtl/fighter_keys_pkg.sv
// Shared keyboard mapping for the fighter player inputs: USB HID usage codes,
// snapshot bit positions and the left/right arbiter state.
package fighter_keys_pkg;

  localparam logic [7:0] KC_W     = 8'h1A;
  localparam logic [7:0] KC_A     = 8'h04;
  localparam logic [7:0] KC_D     = 8'h07;
  localparam logic [7:0] KC_F     = 8'h09;
  localparam logic [7:0] KC_UP    = 8'h52;
  localparam logic [7:0] KC_LEFT  = 8'h50;
  localparam logic [7:0] KC_RIGHT = 8'h4F;
  localparam logic [7:0] KC_J     = 8'h0D;

  localparam int unsigned KB_UP    = 7;
  localparam int unsigned KB_LEFT  = 6;
  localparam int unsigned KB_RIGHT = 5;
  localparam int unsigned KB_PUNCH = 4;

  typedef enum logic [1:0] {DIR_NONE, DIR_LEFT, DIR_RIGHT} dir_e;

  typedef struct packed {
    logic up;
    logic left;
    logic right;
    logic punch;
  } keys_t;

  // At most one key event per cycle, so at most one of the make/break inputs is set.
  function automatic dir_e dir_next(dir_e cur, logic held_l, logic held_r,
                                    logic mk_l, logic mk_r, logic brk_l, logic brk_r);
    dir_e n;
    n = cur;
    if (mk_l)                            n = DIR_LEFT;
    else if (mk_r)                       n = DIR_RIGHT;
    else if (brk_l && cur == DIR_LEFT)   n = held_r ? DIR_RIGHT : DIR_NONE;
    else if (brk_r && cur == DIR_RIGHT)  n = held_l ? DIR_LEFT : DIR_NONE;
    return n;
  endfunction

  function automatic logic [7:0] pack_keys(logic up, logic punch, dir_e d);
    logic [7:0] b;
    b           = '0;
    b[KB_UP]    = up;
    b[KB_LEFT]  = (d == DIR_LEFT);
    b[KB_RIGHT] = (d == DIR_RIGHT);
    b[KB_PUNCH] = punch;
    return b;
  endfunction

endpackage

// File: rtl/key_state_tracker_frame_edge_detect.sv
// Registered rising-edge detector for the frame clock, sampled in the Clk domain.
module frame_edge_detect (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic rise
);

  logic frame_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_d <= '0;
      rise    <= '0;
    end else begin
      frame_d <= frame_clk;
      rise    <= frame_clk & ~frame_d;
    end
  end

endmodule

// File: rtl/key_state_tracker.sv
// Turns the USB keyboard make/break stream into frame-synchronous per-player key bitmaps.
// Define KEY_TAP_LATCH_EN to stretch sub-frame taps so they show for one frame.
module key_state_tracker
  import fighter_keys_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       key_valid,
  input  logic [7:0] keycode,
  input  logic       press,
  output logic [7:0] keypress_p1,
  output logic [7:0] keypress_p2,
  output logic [7:0] last_keycode,
  output logic       frame_tick
);

  logic       rise;
  keys_t      hit  [2];
  keys_t      mk   [2];
  keys_t      brk  [2];
  keys_t      held [2];
  dir_e       dir  [2];
  logic [7:0] snap [2];
  logic [7:0] pending_kc;

  frame_edge_detect u_edge (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .rise      (rise)
  );

`ifdef KEY_TAP_LATCH_EN
  logic tap_up    [2];
  logic tap_punch [2];
  dir_e tap_dir   [2];
  dir_e eff_dir   [2];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned p = 0; p < 2; p++) begin
        tap_up[p]    <= '0;
        tap_punch[p] <= '0;
        tap_dir[p]   <= DIR_NONE;
      end
    end else begin
      // Clearing on load still keeps a make arriving in the load cycle.
      for (int unsigned p = 0; p < 2; p++) begin
        tap_up[p]    <= (rise ? 1'b0 : tap_up[p])    | mk[p].up;
        tap_punch[p] <= (rise ? 1'b0 : tap_punch[p]) | mk[p].punch;
        if (mk[p].left)       tap_dir[p] <= DIR_LEFT;
        else if (mk[p].right) tap_dir[p] <= DIR_RIGHT;
        else if (rise)        tap_dir[p] <= DIR_NONE;
      end
    end
  end
`endif

  always_comb begin
    hit[0] = keys_t'({keycode == KC_W,  keycode == KC_A,    keycode == KC_D,     keycode == KC_F});
    hit[1] = keys_t'({keycode == KC_UP, keycode == KC_LEFT, keycode == KC_RIGHT, keycode == KC_J});
    for (int unsigned p = 0; p < 2; p++) begin
      mk[p]  = (key_valid &&  press) ? keys_t'(hit[p] & ~held[p]) : '0;
      brk[p] = (key_valid && !press) ? keys_t'(hit[p] &  held[p]) : '0;
`ifdef KEY_TAP_LATCH_EN
      // The most recent direction make this frame overrides the held arbitration.
      eff_dir[p] = (tap_dir[p] != DIR_NONE) ? tap_dir[p] : dir[p];
      snap[p]    = pack_keys(held[p].up | tap_up[p], held[p].punch | tap_punch[p], eff_dir[p]);
`else
      snap[p]    = pack_keys(held[p].up, held[p].punch, dir[p]);
`endif
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned p = 0; p < 2; p++) begin
        held[p] <= '0;
        dir[p]  <= DIR_NONE;
      end
      pending_kc   <= '0;
      keypress_p1  <= '0;
      keypress_p2  <= '0;
      last_keycode <= '0;
      frame_tick   <= '0;
    end else begin
      frame_tick <= rise;
      if (rise) begin
        keypress_p1  <= snap[0];
        keypress_p2  <= snap[1];
        last_keycode <= pending_kc;
      end
      if (key_valid && press) pending_kc <= keycode;
      for (int unsigned p = 0; p < 2; p++) begin
        held[p] <= keys_t'((held[p] | mk[p]) & ~brk[p]);
        dir[p]  <= dir_next(dir[p], held[p].left, held[p].right,
                            mk[p].left, mk[p].right, brk[p].left, brk[p].right);
      end
    end
  end

endmodule

// File: tb/tb_key_state_tracker.sv
// Directed self-checking bench for key_state_tracker; follows KEY_TAP_LATCH_EN when defined.
module tb_key_state_tracker;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic       key_valid;
  logic [7:0] keycode;
  logic       press;
  logic [7:0] keypress_p1;
  logic [7:0] keypress_p2;
  logic [7:0] last_keycode;
  logic       frame_tick;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  key_state_tracker dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_clk    (frame_clk),
    .key_valid    (key_valid),
    .keycode      (keycode),
    .press        (press),
    .keypress_p1  (keypress_p1),
    .keypress_p2  (keypress_p2),
    .last_keycode (last_keycode),
    .frame_tick   (frame_tick)
  );

  task automatic apply_reset();
    @(negedge Clk);
    Reset = 1'b1; key_valid = 1'b0; frame_clk = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic key_event(input logic [7:0] kc, input logic pr);
    @(negedge Clk);
    key_valid = 1'b1; keycode = kc; press = pr;
    @(negedge Clk);
    key_valid = 1'b0;
  endtask

  // Raises frame_clk and returns at the negedge inside the frame_tick cycle.
  task automatic wait_tick();
    bit seen;
    seen = 0;
    @(negedge Clk);
    frame_clk = 1'b1;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge Clk);
      if (frame_tick === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL frame_tick_timeout got none want pulse within 8 cycles");
    end
  endtask

  task automatic end_frame();
    @(negedge Clk);
    frame_clk = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Reset = 1'b1; frame_clk = 1'b0; key_valid = 1'b0; keycode = '0; press = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    checks++; if (keypress_p1 !== 8'h00) begin errors++; $display("FAIL reset_p1 got %h want 00", keypress_p1); end
    checks++; if (keypress_p2 !== 8'h00) begin errors++; $display("FAIL reset_p2 got %h want 00", keypress_p2); end
    checks++; if (last_keycode !== 8'h00) begin errors++; $display("FAIL reset_last got %h want 00", last_keycode); end
    checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", frame_tick); end
  endtask

  task automatic test_idle_frames();
    for (int f = 0; f < 3; f++) begin
      wait_tick();
      checks++; if (keypress_p1 !== 8'h00) begin errors++; $display("FAIL idle_p1 frame %0d got %h want 00", f, keypress_p1); end
      checks++; if (keypress_p2 !== 8'h00) begin errors++; $display("FAIL idle_p2 frame %0d got %h want 00", f, keypress_p2); end
      checks++; if (last_keycode !== 8'h00) begin errors++; $display("FAIL idle_last frame %0d got %h want 00", f, last_keycode); end
      end_frame();
    end
  endtask

  task automatic test_direction();
    apply_reset();
    key_event(8'h04, 1'b1);
    wait_tick();
    checks++; if (keypress_p1 !== 8'h40) begin errors++; $display("FAIL dir_left got %h want 40", keypress_p1); end
    checks++; if (last_keycode !== 8'h04) begin errors++; $display("FAIL dir_last_a got %h want 04", last_keycode); end
    end_frame();
    key_event(8'h07, 1'b1);
    wait_tick();
    checks++; if (keypress_p1 !== 8'h20) begin errors++; $display("FAIL dir_right_wins got %h want 20", keypress_p1); end
    checks++; if (last_keycode !== 8'h07) begin errors++; $display("FAIL dir_last_d got %h want 07", last_keycode); end
    end_frame();
    key_event(8'h07, 1'b0);
    wait_tick();
    checks++; if (keypress_p1 !== 8'h40) begin errors++; $display("FAIL dir_back_left got %h want 40", keypress_p1); end
    checks++; if (last_keycode !== 8'h07) begin errors++; $display("FAIL dir_last_after_break got %h want 07", last_keycode); end
    end_frame();
  endtask

  // Relies on A still held from test_direction.
  task automatic test_stable();
    key_event(8'h09, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      checks++; if (keypress_p1 !== 8'h40) begin errors++; $display("FAIL stable_p1 cycle %0d got %h want 40", i, keypress_p1); end
      checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL stable_tick cycle %0d got %b want 0", i, frame_tick); end
    end
    wait_tick();
    checks++; if (keypress_p1 !== 8'h50) begin errors++; $display("FAIL punch_left got %h want 50", keypress_p1); end
    @(negedge Clk);
    checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL tick_width got %b want 0", frame_tick); end
    frame_clk = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_multi();
    apply_reset();
    key_event(8'h09, 1'b1);
    key_event(8'h1A, 1'b1);
    key_event(8'h50, 1'b1);
    wait_tick();
    checks++; if (keypress_p1 !== 8'h90) begin errors++; $display("FAIL multi_p1 got %h want 90", keypress_p1); end
    checks++; if (keypress_p2 !== 8'h40) begin errors++; $display("FAIL multi_p2 got %h want 40", keypress_p2); end
    checks++; if (last_keycode !== 8'h50) begin errors++; $display("FAIL multi_last got %h want 50", last_keycode); end
    end_frame();
  endtask

  task automatic test_conflict();
    apply_reset();
    key_event(8'h04, 1'b1);
    wait_tick(); end_frame();
    key_event(8'h07, 1'b1);
    key_event(8'h4F, 1'b1);
    wait_tick();
    checks++; if (keypress_p1 !== 8'h20) begin errors++; $display("FAIL conflict_both_held got %h want 20", keypress_p1); end
    checks++; if (keypress_p2 !== 8'h20) begin errors++; $display("FAIL conflict_p2_right got %h want 20", keypress_p2); end
    end_frame();
    key_event(8'h04, 1'b0);
    wait_tick();
    checks++; if (keypress_p1 !== 8'h20) begin errors++; $display("FAIL conflict_break_inactive got %h want 20", keypress_p1); end
    end_frame();
    key_event(8'h07, 1'b0);
    wait_tick();
    checks++; if (keypress_p1 !== 8'h00) begin errors++; $display("FAIL conflict_all_released got %h want 00", keypress_p1); end
    end_frame();
  endtask

  task automatic test_same_cycle();
    apply_reset();
    @(negedge Clk);
    frame_clk = 1'b1;
    @(negedge Clk);
    key_valid = 1'b1; keycode = 8'h07; press = 1'b1;
    @(negedge Clk);
    key_valid = 1'b0;
    checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL same_cycle_tick got %b want 1", frame_tick); end
    checks++; if (keypress_p1 !== 8'h00) begin errors++; $display("FAIL same_cycle_excluded got %h want 00", keypress_p1); end
    checks++; if (last_keycode !== 8'h00) begin errors++; $display("FAIL same_cycle_last got %h want 00", last_keycode); end
    end_frame();
    wait_tick();
    checks++; if (keypress_p1 !== 8'h20) begin errors++; $display("FAIL same_cycle_next got %h want 20", keypress_p1); end
    checks++; if (last_keycode !== 8'h07) begin errors++; $display("FAIL same_cycle_next_last got %h want 07", last_keycode); end
    end_frame();
  endtask

  task automatic test_tap();
    logic [7:0] exp_tap;
    logic [7:0] exp_dir;
`ifdef KEY_TAP_LATCH_EN
    exp_tap = 8'h10;
    exp_dir = 8'h20;
`else
    exp_tap = 8'h00;
    exp_dir = 8'h00;
`endif
    apply_reset();
    key_event(8'h0D, 1'b1);
    key_event(8'h0D, 1'b0);
    wait_tick();
    checks++; if (keypress_p2 !== exp_tap) begin errors++; $display("FAIL tap_punch got %h want %h", keypress_p2, exp_tap); end
    checks++; if (last_keycode !== 8'h0D) begin errors++; $display("FAIL tap_last got %h want 0d", last_keycode); end
    end_frame();
    wait_tick();
    checks++; if (keypress_p2 !== 8'h00) begin errors++; $display("FAIL tap_expired got %h want 00", keypress_p2); end
    end_frame();
    key_event(8'h04, 1'b1);
    key_event(8'h07, 1'b1);
    key_event(8'h07, 1'b0);
    key_event(8'h04, 1'b0);
    wait_tick();
    checks++; if (keypress_p1 !== exp_dir) begin errors++; $display("FAIL tap_dir_later_wins got %h want %h", keypress_p1, exp_dir); end
    end_frame();
    wait_tick();
    checks++; if (keypress_p1 !== 8'h00) begin errors++; $display("FAIL tap_dir_expired got %h want 00", keypress_p1); end
    end_frame();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    key_event(8'h04, 1'b1);
    wait_tick();
    checks++; if (keypress_p1 !== 8'h40) begin errors++; $display("FAIL midreset_pre got %h want 40", keypress_p1); end
    end_frame();
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    checks++; if (keypress_p1 !== 8'h00) begin errors++; $display("FAIL midreset_immediate got %h want 00", keypress_p1); end
    checks++; if (last_keycode !== 8'h00) begin errors++; $display("FAIL midreset_last got %h want 00", last_keycode); end
    wait_tick();
    checks++; if (keypress_p1 !== 8'h00) begin errors++; $display("FAIL midreset_next got %h want 00", keypress_p1); end
    end_frame();
  endtask

  initial begin
    test_reset();
    test_idle_frames();
    test_direction();
    test_stable();
    test_multi();
    test_conflict();
    test_same_cycle();
    test_tap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
